// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote oversampling, optional parity, and a
// first-word fall-through receive FIFO with sticky overrun.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_BITS-1:0]          m_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          clr_err
);
    localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W    = $clog2(OVERSAMPLE);
    localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] SMP_LO  = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] SMP_MID = CNT_W'(OVERSAMPLE/2);
    localparam logic [CNT_W-1:0] SMP_HI  = CNT_W'(OVERSAMPLE/2 + 1);
    localparam logic [CNT_W-1:0] SMP_TOP = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic sync1_q, sync2_q, sync1_d, sync2_d, rx_s;
    logic [DIV_W-1:0] div_q, div_d;
    logic tick;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        rx_s    = sync2_q;
        tick    = (div_q == DIV_W'(TICK_DIV - 1));
        div_d   = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            div_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            div_q   <= div_d;
        end
    end

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q, cnt_nx;
    logic [1:0]             ones_q;
    logic                   bit_q, par_q, push_q, frame_err_q, parity_err_q;
    logic [BIT_W-1:0]       idx_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   wrap, vote, par_fail;

    // The detecting tick is sample 0, so each tick's sample index is the
    // incremented counter value; this keeps the vote window centred.
    always_comb begin
        cnt_nx   = (cnt_q == SMP_TOP) ? '0 : cnt_q + 1'b1;
        wrap     = (cnt_nx == '0);
        vote     = (ones_q == 2'd2) || ((ones_q == 2'd1) && rx_s);
        par_fail = (PARITY != 0) && (((^shreg_q) ^ par_q) != (PARITY == 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ones_q       <= '0;
            bit_q        <= 1'b0;
            idx_q        <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            if (tick && state_q == S_IDLE) begin
                if (!rx_s) begin
                    state_q <= S_START;
                    cnt_q   <= '0;
                end
            end else if (tick) begin
                cnt_q <= cnt_nx;
                if (cnt_nx == SMP_LO)  ones_q <= {1'b0, rx_s};
                if (cnt_nx == SMP_MID) ones_q <= ones_q + {1'b0, rx_s};
                if (cnt_nx == SMP_HI)  bit_q  <= vote;
                case (state_q)
                    S_START: begin
                        if (cnt_nx == SMP_HI && vote) state_q <= S_IDLE;
                        else if (wrap) begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end
                    end
                    S_DATA: begin
                        if (wrap) begin
                            shreg_q <= {bit_q, shreg_q[DATA_BITS-1:1]};
                            if (idx_q == BIT_W'(DATA_BITS - 1))
                                state_q <= (PARITY != 0) ? S_PAR : S_STOP;
                            else
                                idx_q <= idx_q + 1'b1;
                        end
                    end
                    S_PAR: begin
                        if (wrap) begin
                            par_q   <= bit_q;
                            state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        // Leave mid-stop-bit so an early next start edge is caught.
                        if (cnt_nx == SMP_HI) begin
                            frame_err_q  <= !vote;
                            parity_err_q <= par_fail;
                            push_q       <= vote && !par_fail;
                            state_q      <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic                 ovr_q, ovr_d, full, pop, wr_en;

    always_comb begin
        count   = wr_q - rd_q;
        m_valid = (count != '0);
        full    = (count == (AW+1)'(FIFO_DEPTH));
        pop     = m_valid && m_ready;
        wr_en   = push_q && (!full || pop);
        wr_d    = wr_q + (AW+1)'(wr_en);
        rd_d    = rd_q + (AW+1)'(pop);
        ovr_d   = (ovr_q && !clr_err) || (push_q && full && !pop);
        m_data  = m_valid ? mem_q[rd_q[AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= shreg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovr_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovr_q <= ovr_d;
        end
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = ovr_q;
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter CLOCK_FREQ, default 50000000, clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 9600, line rate in bit/s.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, 8..32).
REQ-005 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-007 SHALL have port clk, input, 1, clock; rising edge only.
REQ-008 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-009 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port m_valid, output, 1, FIFO head word available.
REQ-011 SHALL have port m_ready, input, 1, consumer accepts head word.
REQ-012 SHALL have port m_data, output, DATA_BITS, FIFO head word.
REQ-013 SHALL have port count, output, clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-014 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-015 SHALL have port parity_err, output, 1, one-cycle pulse on a parity mismatch.
REQ-016 SHALL have port overrun, output, 1, sticky; a word was dropped because the FIFO was full.
REQ-017 SHALL have port clr_err, input, 1, clears overrun.

Function
REQ-018 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-019 SHALL derive a one-cycle tick every TICK_DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks; the divider free-runs and its integer truncation is accepted.
REQ-020 SHALL run the FSM states IDLE, START, DATA, PARITY, STOP; a sample counter (0..OVERSAMPLE-1) advances on each tick in states other than IDLE.
REQ-021 SHALL, in IDLE, move to START on the first tick at which synchronized rx=0, clearing the sample counter.
REQ-022 SHALL decide each bit by majority vote of the samples at counter values OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-023 SHALL, in START, return to IDLE on a voted 1 (false start) with no flags set; on a voted 0 it SHALL enter DATA at counter wrap.
REQ-024 SHALL shift DATA bits LSB first; after DATA_BITS bits it SHALL enter PARITY if PARITY!=0, otherwise STOP.
REQ-025 SHALL compute the parity check over the data bits plus the parity bit: odd mode expects XOR=1, even mode expects XOR=0.
REQ-026 SHALL act in STOP on the voted stop bit. On 0: pulse frame_err, discard the word. On parity fail: pulse parity_err, discard the word. Both failures SHALL pulse both flags in the same cycle.
REQ-027 SHALL push a good word in the cycle after the stop vote and return to IDLE immediately, so a start edge in the second half of the stop bit is accepted.
REQ-028 SHALL present the FIFO as first-word fall-through: the push into an empty FIFO gives m_valid=1 on the next cycle.
REQ-029 SHALL pop when m_valid & m_ready; m_data SHALL stay stable while m_valid & !m_ready.
REQ-030 SHALL, on a push while full without a pop, drop the new word, keep the stored contents, and set overrun.
REQ-031 SHALL, on a push and pop in the same cycle while full, accept both with count unchanged and no overrun.
REQ-032 SHALL handle pointer wrap at FIFO_DEPTH transparently; count SHALL equal the number of stored words, 0..FIFO_DEPTH.
REQ-033 SHALL clear overrun on clr_err; a simultaneous set and clear SHALL leave overrun=1.

Reset
REQ-034 SHALL, on rst, set the state to IDLE and clear the divider, sample counter and FIFO pointers.
REQ-035 SHALL, on rst, drive m_valid=0, count=0, m_data=0, frame_err=0, parity_err=0, overrun=0.
REQ-036 SHALL abort a frame that is in progress when rst is asserted, and never deliver that partial word.

Verification (CLOCK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16 -> 160 clk/bit)
REQ-037 SHALL cover: PARITY=0, frame 0x A5 -> m_data=0xA5, m_valid=1, count=1, no flags.
REQ-038 SHALL cover: PARITY=2, 0x3C sent with wrong parity bit -> parity_err pulse, count stays 0.
REQ-039 SHALL cover: stop bit driven 0 -> frame_err pulse, nothing pushed; a 40-clk low glitch on an idle line -> no word, no flags.
REQ-040 SHALL cover: 9 frames 0x01..0x09 with m_ready=0 -> count=8, overrun=1, reads return 0x01..0x08; clr_err -> overrun=0.
REQ-041 SHALL cover: rst mid-DATA, then frame 0x5A -> only 0x5A delivered.
REQ-042 SHALL cover: back-to-back frames with a new start at 60% of the stop bit and m_ready=1 -> both words delivered in order, m_data stable while stalled.
